// File: rtl/sweep_eval_circuit.sv
// Per-channel evaluator f = (~x & z) | y with an exhaustive 8-step self-sweep (IDLE/RUN/DONE FSM).
// Optional macro BIST_CHECK_EN adds a per-step comparator against truth vector 8'hCE that drives err.
module sweep_eval_circuit #(
    parameter int W = 4,
    localparam int CW = $clog2(8*W+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  z,
    input  logic          in_valid,
    input  logic          sweep_start,
    output logic [W-1:0]  op,
    output logic          out_valid,
    output logic          sweep_busy,
    output logic          sweep_done,
    output logic [2:0]    sweep_idx,
    output logic [CW-1:0] ones_cnt,
    output logic          err,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state, next_state;
    logic [W-1:0]  ex, ey, ez, f_vec;
    logic [CW-1:0] f_ones;

    // Handshake: in_valid is sampled only in IDLE; out_valid is high for exactly the cycle
    // after a sampled request or RUN step, and op holds its value whenever out_valid is low.
    always_comb begin
        ex = x;
        ey = y;
        ez = z;
        if (state == RUN) begin
            ex = {W{sweep_idx[2]}};
            ey = {W{sweep_idx[1]}};
            ez = {W{sweep_idx[0]}};
        end
    end

    assign f_vec = (~ex & ez) | ey;

    always_comb begin
        f_ones = '0;
        for (int i = 0; i < W; i++) begin
            f_ones = f_ones + CW'(f_vec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sweep_start) next_state = RUN;
            RUN:     if (sweep_idx == 3'd7) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign sweep_busy = (state == RUN);
    assign sweep_done = (state == DONE);
    assign state_dbg  = state;

    // sweep_idx wraps 7 -> 0 on the last RUN step, so it is already cleared in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= '0;
            out_valid <= 1'b0;
            sweep_idx <= '0;
            ones_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        sweep_idx <= '0;
                        ones_cnt  <= '0;
                    end else if (in_valid) begin
                        op        <= f_vec;
                        out_valid <= 1'b1;
                    end
                end
                RUN: begin
                    op        <= f_vec;
                    out_valid <= 1'b1;
                    ones_cnt  <= ones_cnt + f_ones;
                    sweep_idx <= sweep_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIST_CHECK_EN
    localparam logic [7:0] TRUTH = 8'hCE;
    logic step_bad;

    assign step_bad = (state == RUN) && (f_vec != {W{TRUTH[sweep_idx]}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && sweep_start) begin
            err <= 1'b0;
        end else if (step_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_eval_circuit.sv
// Scoreboard bench for sweep_eval_circuit: directed vectors push expected op values,
// a negedge monitor pops and compares them whenever out_valid is high.
module tb_sweep_eval_circuit;

    localparam int W  = 4;
    localparam int CW = $clog2(8*W+1);
    localparam logic [7:0] TT = 8'hCE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  x, y, z;
    logic          in_valid, sweep_start;
    logic [W-1:0]  op;
    logic          out_valid, sweep_busy, sweep_done, err;
    logic [2:0]    sweep_idx;
    logic [CW-1:0] ones_cnt;
    logic [1:0]    state_dbg;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_pulses = 0;
    int exp_done = 0;

    sweep_eval_circuit #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
        .in_valid(in_valid), .sweep_start(sweep_start),
        .op(op), .out_valid(out_valid), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .sweep_idx(sweep_idx),
        .ones_cnt(ones_cnt), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                           input logic [W-1:0] zv);
        logic [W-1:0] r;
        logic [7:0]   tt;
        tt = TT;
        for (int i = 0; i < W; i++) r[i] = tt[{xv[i], yv[i], zv[i]}];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got op=%0h with no expected entry", op);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (op !== e) begin
                    n_err++;
                    $display("FAIL op_result: got %0h expected %0h", op, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && sweep_done === 1'b1) done_pulses++;
    end

    // drivers
    task automatic eval_vec(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [W-1:0] zv);
        @(negedge clk);
        x = xv; y = yv; z = zv;
        in_valid = 1'b1;
        sweep_start = 1'b0;
        exp_q.push_back(model(xv, yv, zv));
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        sweep_start = 1'b0;
    endtask

    task automatic run_sweep(input bit collide, input bit repulse, input bit forced);
        logic [7:0]   tt;
        logic [W-1:0] step_exp;
        int           busy_cnt;
        int           exp_ones;
        tt = TT;
        exp_ones = forced ? 8 : 5*W;
        @(negedge clk);
        sweep_start = 1'b1;
        in_valid = collide;
        x = '1; y = '1; z = '1;
        for (int s = 0; s < 8; s++) begin
            step_exp = forced ? W'(1) : {W{tt[s]}};
            exp_q.push_back(step_exp);
        end
        @(negedge clk);
        sweep_start = 1'b0;
        in_valid = 1'b0;
        check("sweep_cnt_clear", ones_cnt, 0);
        check("err_clear", err, 0);
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (sweep_busy !== 1'b1) break;
            check("sweep_idx", sweep_idx, c);
            if (c == 1) check("err_step", err, forced);
            busy_cnt++;
            sweep_start = (repulse && c == 3);
            @(negedge clk);
        end
        sweep_start = 1'b0;
        check("busy_cycles", busy_cnt, 8);
        check("sweep_done", sweep_done, 1);
        check("ones_cnt", ones_cnt, exp_ones);
        check("err_done", err, forced);
        exp_done++;
        @(negedge clk);
        check("done_one_cycle", sweep_done, 0);
        check("busy_after", sweep_busy, 0);
        check("ones_hold", ones_cnt, exp_ones);
    endtask

    initial begin
        logic [7:0] tt;
        tt = TT;
        rst_n = 1'b0;
        x = '0; y = '0; z = '0;
        in_valid = 1'b0;
        sweep_start = 1'b0;
        #1;
        check("rst_op", op, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_ones", ones_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single evaluation, then hold
        eval_vec(4'b0000, 4'b0000, 4'b1010);
        go_idle();
        @(negedge clk);
        check("op_hold_single", op, 4'b1010);
        check("out_valid_pulse", out_valid, 0);

        // back-to-back evaluations
        eval_vec(4'hF, 4'h0, 4'hF);
        eval_vec(4'h0, 4'h5, 4'h0);
        eval_vec(4'h3, 4'h0, 4'hF);
        eval_vec(4'h0, 4'hA, 4'h5);
        go_idle();
        @(negedge clk);
        check("op_hold_b2b", op, 4'hF);
        check("out_valid_idle", out_valid, 0);

        // plain full sweep
        run_sweep(1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_op", op, 0);
        check("async_out_valid", out_valid, 0);
        check("async_busy", sweep_busy, 0);
        check("async_done", sweep_done, 0);
        check("async_idx", sweep_idx, 0);
        check("async_ones", ones_cnt, 0);
        check("async_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // collisions: in_valid with sweep_start, and sweep_start re-pulsed during RUN
        run_sweep(1'b1, 1'b1, 1'b0);

        // abort at sweep_idx 4
        @(negedge clk);
        sweep_start = 1'b1;
        for (int s = 0; s < 4; s++) exp_q.push_back({W{tt[s]}});
        @(negedge clk);
        sweep_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sweep_idx == 3'd4) break;
            @(negedge clk);
        end
        check("abort_reach_idx", sweep_idx, 4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_idx", sweep_idx, 0);
        check("abort_ones", ones_cnt, 0);
        check("abort_busy", sweep_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle", state_dbg, 0);

        // fresh sweep after abort
        run_sweep(1'b0, 1'b0, 1'b0);

`ifdef BIST_CHECK_EN
        force dut.f_vec = W'(1);
        run_sweep(1'b0, 1'b0, 1'b1);
        release dut.f_vec;
        run_sweep(1'b0, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_pulses, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
